// File: rtl/acquisition_controller.sv
// Capture sequencer for one MSO acquisition: fills the pre-trigger window,
// arms trigger_hub, waits for a real or auto-forced trigger, captures the
// post-trigger window into the circular sample buffer, then flags done.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start
//   S_PRE   | filling the pre-trigger window
//   S_ARMED | hub armed, writing circularly until trigger or auto timeout
//   S_POST  | filling the post-trigger window
//   S_DONE  | capture complete, addresses held until start/abort
module acquisition_controller #(
  parameter int ADDR_WIDTH    = 10,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     auto_mode,
  input  logic [ADDR_WIDTH-1:0]    pre_samples,
  input  logic [ADDR_WIDTH-1:0]    post_samples,
  input  logic [TIMEOUT_WIDTH-1:0] auto_timeout,
  input  logic                     sample_valid,
  input  logic                     trigger_state,
  output logic                     trig_arm,
  output logic                     trig_reset,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [ADDR_WIDTH-1:0]    trig_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     forced
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]    trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    pre_q, pre_d;
  logic [ADDR_WIDTH-1:0]    post_q, post_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
  logic                     done_q, done_d;
  logic                     forced_q, forced_d;
  logic                     trig_reset_q, trig_reset_d;

  logic                     write;
  logic [ADDR_WIDTH-1:0]    cnt_inc;
  logic [TIMEOUT_WIDTH-1:0] tmo_inc;
  logic                     timeout_hit;

  // State and datapath registers; reset lands immediately, even mid-capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      tmo_q        <= '0;
      timeout_q    <= '0;
      done_q       <= 1'b0;
      forced_q     <= 1'b0;
      trig_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      trig_addr_q  <= trig_addr_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      tmo_q        <= tmo_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
      forced_q     <= forced_d;
      trig_reset_q <= trig_reset_d;
    end
  end

  // Next-state, counters and write strobe. A zero-length window spends its
  // single cycle without writing, so PRE/POST writes are gated on a nonzero count.
  always_comb begin
    state_d      = state_q;
    trig_addr_d  = trig_addr_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    post_d       = post_q;
    tmo_d        = tmo_q;
    timeout_d    = timeout_q;
    done_d       = done_q;
    forced_d     = forced_q;
    trig_reset_d = 1'b0;

    write = sample_valid & (((state_q == S_PRE)  && (pre_q  != '0)) ||
                             (state_q == S_ARMED) ||
                            ((state_q == S_POST) && (post_q != '0)));
    wr_addr_d   = write ? wr_addr_q + ADDR_WIDTH'(1) : wr_addr_q;
    cnt_inc     = cnt_q + ADDR_WIDTH'(1);
    tmo_inc     = tmo_q + TIMEOUT_WIDTH'(1);
    timeout_hit = auto_mode && (timeout_q != '0) && write && (tmo_inc == timeout_q);

    if (abort) begin
      state_d      = S_IDLE;
      trig_reset_d = 1'b1;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pre_d        = pre_samples;
            post_d       = post_samples;
            timeout_d    = auto_timeout;
            wr_addr_d    = '0;
            cnt_d        = '0;
            tmo_d        = '0;
            forced_d     = 1'b0;
            done_d       = 1'b0;
            trig_reset_d = 1'b1;
            state_d      = S_PRE;
          end
        end
        S_PRE: begin
          if (pre_q == '0) begin
            state_d = S_ARMED;
          end else if (write) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_q) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (write) tmo_d = tmo_inc;
          // trig_addr points at the first sample after the trigger-detect write.
          if (trigger_state || timeout_hit) begin
            state_d     = S_POST;
            trig_addr_d = wr_addr_d;
            cnt_d       = '0;
            forced_d    = !trigger_state;
          end
        end
        S_POST: begin
          if (post_q == '0) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            trig_reset_d = 1'b1;
          end else if (write) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_q) begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              trig_reset_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    wr_en      = write;
    wr_addr    = wr_addr_q;
    trig_addr  = trig_addr_q;
    trig_arm   = (state_q == S_ARMED);
    busy       = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    done       = done_q;
    forced     = forced_q;
    trig_reset = trig_reset_q;
  end

endmodule

// File: tb/tb_acquisition_controller.sv
// Directed bench for acquisition_controller: a cycle table for the basic
// capture plus hand-written sequences for reset, abort, auto timeout,
// zero-length windows and address wraparound (second instance, ADDR_WIDTH=3).
module tb_acquisition_controller;

  logic        clk, rst;
  logic        start, abort, auto_mode, sample_valid, trigger_state;
  logic [9:0]  pre_samples, post_samples;
  logic [15:0] auto_timeout;
  logic        trig_arm, trig_reset, wr_en, busy, done, forced;
  logic [9:0]  wr_addr, trig_addr;

  logic        start2;
  logic [2:0]  pre2, post2;
  logic        trig_arm2, trig_reset2, wr_en2, busy2, done2, forced2;
  logic [2:0]  wr_addr2, trig_addr2;

  int n_vec = 0;
  int n_err = 0;

  acquisition_controller #(.ADDR_WIDTH(10), .TIMEOUT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .auto_mode(auto_mode),
    .pre_samples(pre_samples), .post_samples(post_samples), .auto_timeout(auto_timeout),
    .sample_valid(sample_valid), .trigger_state(trigger_state),
    .trig_arm(trig_arm), .trig_reset(trig_reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .trig_addr(trig_addr), .busy(busy), .done(done), .forced(forced));

  acquisition_controller #(.ADDR_WIDTH(3), .TIMEOUT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .auto_mode(1'b0),
    .pre_samples(pre2), .post_samples(post2), .auto_timeout(16'd0),
    .sample_valid(sample_valid), .trigger_state(trigger_state),
    .trig_arm(trig_arm2), .trig_reset(trig_reset2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .trig_addr(trig_addr2), .busy(busy2), .done(done2), .forced(forced2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, ab, v, tr;
    logic       we;
    logic [9:0] wa;
    logic       arm, trs, bsy, dn;
    logic [9:0] ta;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic s, input logic a, input logic v, input logic t);
    start = s; abort = a; sample_valid = v; trigger_state = t;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  writes;
    logic finished;

    // pre=4 post=3, trigger on the second ARMED sample: writes 0..8, trig_addr 6
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,10'd0,1'b0,1'b0,1'b0,1'b0,10'd0};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd0,1'b0,1'b1,1'b1,1'b0,10'd0};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd1,1'b0,1'b0,1'b1,1'b0,10'd0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd2,1'b0,1'b0,1'b1,1'b0,10'd0};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd3,1'b0,1'b0,1'b1,1'b0,10'd0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd4,1'b1,1'b0,1'b1,1'b0,10'd0};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b1, 1'b1,10'd5,1'b1,1'b0,1'b1,1'b0,10'd0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd6,1'b0,1'b0,1'b1,1'b0,10'd6};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd7,1'b0,1'b0,1'b1,1'b0,10'd6};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,10'd8,1'b0,1'b0,1'b1,1'b0,10'd6};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,10'd9,1'b0,1'b1,1'b0,1'b1,10'd6};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,10'd9,1'b0,1'b0,1'b0,1'b1,10'd6};

    rst = 1'b1; start = 1'b0; abort = 1'b0; auto_mode = 1'b0;
    sample_valid = 1'b0; trigger_state = 1'b0;
    pre_samples = 10'd0; post_samples = 10'd0; auto_timeout = 16'd0;
    start2 = 1'b0; pre2 = 3'd0; post2 = 3'd0;
    next(); next();
    rst = 1'b0;

    // reset state
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_busy", busy, 0);     check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);   check("rst_wr_addr", wr_addr, 0);
    check("rst_arm", trig_arm, 0);  check("rst_trig_reset", trig_reset, 0);
    check("rst_forced", forced, 0); check("rst_trig_addr", trig_addr, 0);
    next();

    // asynchronous reset in the middle of POST
    pre_samples = 10'd2; post_samples = 10'd5;
    drive(1'b1, 1'b0, 1'b0, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b1); check("r1_armed", trig_arm, 1); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("r1_post_busy", busy, 1); check("r1_post_trig_addr", trig_addr, 3);
    #1 rst = 1'b1;
    #1;
    check("r1_busy", busy, 0);       check("r1_wr_en", wr_en, 0);
    check("r1_wr_addr", wr_addr, 0); check("r1_trig_addr", trig_addr, 0);
    check("r1_done", done, 0);       check("r1_arm", trig_arm, 0);
    #1 rst = 1'b0;
    next();

    // basic capture from the vector table
    pre_samples = 10'd4; post_samples = 10'd3;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].tr);
      check($sformatf("t2[%0d]_wr_en", i), wr_en, tbl[i].we);
      check($sformatf("t2[%0d]_wr_addr", i), wr_addr, tbl[i].wa);
      check($sformatf("t2[%0d]_arm", i), trig_arm, tbl[i].arm);
      check($sformatf("t2[%0d]_trig_reset", i), trig_reset, tbl[i].trs);
      check($sformatf("t2[%0d]_busy", i), busy, tbl[i].bsy);
      check($sformatf("t2[%0d]_done", i), done, tbl[i].dn);
      check($sformatf("t2[%0d]_trig_addr", i), trig_addr, tbl[i].ta);
      next();
    end

    // abort from DONE clears done
    drive(1'b0, 1'b1, 1'b0, 1'b0); next();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("ad_done", done, 0); check("ad_trig_reset", trig_reset, 1); check("ad_busy", busy, 0);
    next();

    // start while busy is ignored; abort+start in ARMED returns to IDLE
    pre_samples = 10'd3; post_samples = 10'd2;
    drive(1'b1, 1'b0, 1'b0, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); check("t6_addr0", wr_addr, 0); next();
    drive(1'b1, 1'b0, 1'b1, 1'b0); check("t6_addr1", wr_addr, 1); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_busy_start_addr", wr_addr, 2); check("t6_busy_start_rst", trig_reset, 0); next();
    drive(1'b1, 1'b1, 1'b1, 1'b0); check("t6_armed", trig_arm, 1); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_ab_busy", busy, 0);       check("t6_ab_done", done, 0);
    check("t6_ab_rst", trig_reset, 1);  check("t6_ab_arm", trig_arm, 0);
    check("t6_ab_wr_en", wr_en, 0);
    next();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_ab_rst_end", trig_reset, 0); check("t6_ab_idle", busy, 0);
    next();

    // auto timeout with no trigger: pre=2, timeout=5, post=3
    auto_mode = 1'b1; auto_timeout = 16'd5;
    pre_samples = 10'd2; post_samples = 10'd3;
    drive(1'b1, 1'b0, 1'b0, 1'b0); next();
    writes = 0; finished = 1'b0;
    for (int c = 0; c < 60 && !finished; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (wr_en) writes++;
      if (done) finished = 1'b1;
      else next();
    end
    check("t3_done_reached", finished, 1);
    check("t3_writes", writes, 10);
    check("t3_forced", forced, 1);
    check("t3_trig_addr", trig_addr, 7);
    check("t3_wr_addr", wr_addr, 10);
    next();

    // timeout write coincides with a real trigger: real trigger wins
    auto_timeout = 16'd3; pre_samples = 10'd1; post_samples = 10'd1;
    drive(1'b1, 1'b0, 1'b0, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b1); check("t4_arm", trig_arm, 1); check("t4_addr", wr_addr, 3); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); check("t4_forced", forced, 0); check("t4_post", busy, 1); next();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_done", done, 1); check("t4_trig_addr", trig_addr, 4); check("t4_forced_end", forced, 0);
    next();

    // zero-length pre and post windows
    auto_mode = 1'b0; auto_timeout = 16'd0; pre_samples = 10'd0; post_samples = 10'd0;
    drive(1'b1, 1'b0, 1'b0, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_pre_wr_en", wr_en, 0); check("t5_pre_busy", busy, 1); check("t5_pre_arm", trig_arm, 0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_armed_arm", trig_arm, 1); check("t5_armed_wr_en", wr_en, 1); next();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_post_wr_en", wr_en, 0); check("t5_post_busy", busy, 1); check("t5_post_arm", trig_arm, 0); next();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_done", done, 1); check("t5_busy", busy, 0);
    check("t5_wr_addr", wr_addr, 1); check("t5_trig_addr", trig_addr, 1);
    next();

    // ADDR_WIDTH=3: pre=7 then trigger on the first ARMED write, post wraps 7->0
    pre2 = 3'd7; post2 = 3'd3;
    start2 = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0); next(); start2 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("w_pre[%0d]_addr", c), wr_addr2, c);
      next();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("w_armed", trig_arm2, 1); check("w_addr7", wr_addr2, 7); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("w_wrap_addr", wr_addr2, 0); check("w_trig_addr", trig_addr2, 0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("w_done", done2, 1); check("w_final_addr", wr_addr2, 3);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
